enemy_shell_ctl: RTL and testbench

ENEMY_SHELL_CTL -- requirements
Module: enemy_shell_ctl

---
 rtl/enemy_shell_ctl.sv | 214 +++++++++++++++++++++
 tb/tb_enemy_shell_ctl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_shell_ctl.sv
// Enemy shell controller: launches a single shell from the enemy barrel,
// moves it once per frame and detects a hit on our tank. After the shell
// leaves the screen or the hit pulse ends, a frame-counted cooldown blocks
// the next launch.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  S_IDLE     | no shell; a valid fire request launches one
//  S_FLIGHT   | shell moving; hit test, then edge test, then move, per frame
//  S_HIT      | hit flag raised; held until the next frame tick
//  S_COOLDOWN | shell gone; counting frames down before the next launch
module enemy_shell_ctl #(
   parameter int SPEED    = 4,
   parameter int COOLDOWN = 30,
   parameter int H_LIMIT  = 800,
   parameter int V_LIMIT  = 600,
   parameter int HIT_HALF = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        fire,
   input  logic [2:0]  fire_dir,
   input  logic [9:0]  xpos_enemy,
   input  logic [9:0]  ypos_enemy,
   input  logic [11:0] xpos_us,
   input  logic [11:0] ypos_us,
   output logic [9:0]  xpos_bullet_red,
   output logic [9:0]  ypos_bullet_red,
   output logic [2:0]  direction_from_enemy,
   output logic        tank_enemy_hit_us,
   output logic        busy,
   output logic [3:0]  hit_count
);

   // Counter is wide enough to hold COOLDOWN, and at least one bit when it is 0.
   localparam int CW = $clog2(COOLDOWN + 2);

   localparam logic [2:0]    DIR_NONE  = 3'd0;
   localparam logic [2:0]    DIR_UP    = 3'd1;
   localparam logic [2:0]    DIR_DOWN  = 3'd2;
   localparam logic [2:0]    DIR_RIGHT = 3'd3;
   localparam logic [2:0]    DIR_LEFT  = 3'd4;

   localparam logic [9:0]    STEP      = 10'(SPEED);
   localparam logic [10:0]   STEP_W    = 11'(SPEED);
   localparam logic [10:0]   X_MAX     = 11'(H_LIMIT - 1);
   localparam logic [10:0]   Y_MAX     = 11'(V_LIMIT - 1);
   localparam logic [12:0]   HIT_W     = 13'(HIT_HALF);
   localparam logic [CW-1:0] CD_LOAD   = CW'(COOLDOWN);
   localparam logic [CW-1:0] CD_ONE    = CW'(1);
   localparam logic [3:0]    HITS_MAX  = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLIGHT,
      S_HIT,
      S_COOLDOWN
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      x_q, x_d;
   logic [9:0]      y_q, y_d;
   logic [2:0]      dir_q, dir_d;
   logic            hit_q, hit_d;
   logic            busy_q, busy_d;
   logic [3:0]      hits_q, hits_d;
   logic [CW-1:0]   cd_q, cd_d;

   logic signed [12:0] dx, dy;
   logic [12:0]        adx, ady;
   logic               near_us;
   logic [10:0]        x_ext, y_ext;
   logic               off_screen;
   logic [9:0]         x_mv, y_mv;
   logic               fire_ok;

   // Distance to our tank (signed, position zero-extended) and hit-box test.
   always_comb begin
      dx      = $signed({3'b000, x_q}) - $signed({1'b0, xpos_us});
      dy      = $signed({3'b000, y_q}) - $signed({1'b0, ypos_us});
      adx     = dx[12] ? 13'(-dx) : 13'(dx);
      ady     = dy[12] ? 13'(-dy) : 13'(dy);
      near_us = (adx <= HIT_W) && (ady <= HIT_W);
   end

   // Candidate next position and whether that move would leave the screen.
   always_comb begin
      x_ext      = {1'b0, x_q};
      y_ext      = {1'b0, y_q};
      off_screen = 1'b0;
      x_mv       = x_q;
      y_mv       = y_q;
      case (dir_q)
         DIR_UP: begin
            off_screen = y_ext < STEP_W;
            y_mv       = y_q - STEP;
         end
         DIR_DOWN: begin
            off_screen = (y_ext + STEP_W) > Y_MAX;
            y_mv       = y_q + STEP;
         end
         DIR_RIGHT: begin
            off_screen = (x_ext + STEP_W) > X_MAX;
            x_mv       = x_q + STEP;
         end
         DIR_LEFT: begin
            off_screen = x_ext < STEP_W;
            x_mv       = x_q - STEP;
         end
         // A flying shell always carries a valid direction; treat anything
         // else as having left the screen so the FSM cannot stall.
         default: off_screen = 1'b1;
      endcase
   end

   assign fire_ok = fire && (fire_dir >= DIR_UP) && (fire_dir <= DIR_LEFT);

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      hit_d   = hit_q;
      hits_d  = hits_q;
      cd_d    = cd_q;
      case (state_q)
         S_IDLE: begin
            // A frame tick in the launch cycle does not move the shell.
            if (fire_ok) begin
               state_d = S_FLIGHT;
               x_d     = xpos_enemy;
               y_d     = ypos_enemy;
               dir_d   = fire_dir;
            end
         end
         S_FLIGHT: begin
            if (frame_tick) begin
               if (near_us) begin
                  state_d = S_HIT;
                  hit_d   = 1'b1;
                  dir_d   = DIR_NONE;
                  if (hits_q != HITS_MAX) begin
                     hits_d = hits_q + 4'd1;
                  end
               end else if (off_screen) begin
                  state_d = S_COOLDOWN;
                  dir_d   = DIR_NONE;
                  cd_d    = CD_LOAD;
               end else begin
                  x_d = x_mv;
                  y_d = y_mv;
               end
            end
         end
         S_HIT: begin
            if (frame_tick) begin
               state_d = S_COOLDOWN;
               hit_d   = 1'b0;
               cd_d    = CD_LOAD;
            end
         end
         S_COOLDOWN: begin
            if (frame_tick) begin
               if (cd_q <= CD_ONE) begin
                  state_d = S_IDLE;
                  cd_d    = '0;
               end else begin
                  cd_d = cd_q - CD_ONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            dir_d   = DIR_NONE;
            hit_d   = 1'b0;
            cd_d    = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         dir_q   <= DIR_NONE;
         hit_q   <= 1'b0;
         busy_q  <= 1'b0;
         hits_q  <= '0;
         cd_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_q   <= dir_d;
         hit_q   <= hit_d;
         busy_q  <= busy_d;
         hits_q  <= hits_d;
         cd_q    <= cd_d;
      end
   end

   assign xpos_bullet_red      = x_q;
   assign ypos_bullet_red      = y_q;
   assign direction_from_enemy = dir_q;
   assign tank_enemy_hit_us    = hit_q;
   assign busy                 = busy_q;
   assign hit_count            = hits_q;

endmodule

// File: tb/tb_enemy_shell_ctl.sv
// Bench for enemy_shell_ctl: directed scenarios followed by random traffic,
// all checked every cycle against a frame-level behavioural model.
module tb_enemy_shell_ctl;

   localparam int SPEED = 4;
   localparam int CD    = 30;
   localparam int HL    = 800;
   localparam int VL    = 600;
   localparam int HH    = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        fire;
   logic [2:0]  fire_dir;
   logic [9:0]  xpos_enemy;
   logic [9:0]  ypos_enemy;
   logic [11:0] xpos_us;
   logic [11:0] ypos_us;
   logic [9:0]  xpos_bullet_red;
   logic [9:0]  ypos_bullet_red;
   logic [2:0]  direction_from_enemy;
   logic        tank_enemy_hit_us;
   logic        busy;
   logic [3:0]  hit_count;

   int checks = 0;
   int errors = 0;

   // Reference model: what the shell is doing, in plain integers.
   typedef enum {M_IDLE, M_FLIGHT, M_HIT, M_COOL} mode_t;
   mode_t m_mode;
   int    m_x, m_y, m_dir, m_hit, m_hits, m_left;

   always #5 clk = ~clk;

   enemy_shell_ctl #(
      .SPEED(SPEED), .COOLDOWN(CD), .H_LIMIT(HL), .V_LIMIT(VL), .HIT_HALF(HH)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .frame_tick          (frame_tick),
      .fire                (fire),
      .fire_dir            (fire_dir),
      .xpos_enemy          (xpos_enemy),
      .ypos_enemy          (ypos_enemy),
      .xpos_us             (xpos_us),
      .ypos_us             (ypos_us),
      .xpos_bullet_red     (xpos_bullet_red),
      .ypos_bullet_red     (ypos_bullet_red),
      .direction_from_enemy(direction_from_enemy),
      .tank_enemy_hit_us   (tank_enemy_hit_us),
      .busy                (busy),
      .hit_count           (hit_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_x = 0; m_y = 0; m_dir = 0; m_hit = 0; m_hits = 0; m_left = 0;
   endtask

   // One clock edge of behaviour, derived from the shell rules.
   task automatic model_clock();
      int ex, ey, nx, ny;
      case (m_mode)
         M_IDLE: begin
            if (fire && fire_dir >= 3'd1 && fire_dir <= 3'd4) begin
               m_mode = M_FLIGHT;
               m_x    = int'(xpos_enemy);
               m_y    = int'(ypos_enemy);
               m_dir  = int'(fire_dir);
            end
         end
         M_FLIGHT: begin
            if (frame_tick) begin
               ex = m_x - int'(xpos_us);
               ey = m_y - int'(ypos_us);
               if (ex < 0) ex = -ex;
               if (ey < 0) ey = -ey;
               if (ex <= HH && ey <= HH) begin
                  m_mode = M_HIT;
                  m_hit  = 1;
                  m_dir  = 0;
                  if (m_hits < 15) m_hits++;
               end else begin
                  nx = m_x;
                  ny = m_y;
                  case (m_dir)
                     1: ny = ny - SPEED;
                     2: ny = ny + SPEED;
                     3: nx = nx + SPEED;
                     default: nx = nx - SPEED;
                  endcase
                  if (nx < 0 || nx >= HL || ny < 0 || ny >= VL) begin
                     m_mode = M_COOL;
                     m_dir  = 0;
                     m_left = CD;
                  end else begin
                     m_x = nx;
                     m_y = ny;
                  end
               end
            end
         end
         M_HIT: begin
            if (frame_tick) begin
               m_mode = M_COOL;
               m_hit  = 0;
               m_left = CD;
            end
         end
         default: begin
            if (frame_tick) begin
               m_left = m_left - 1;
               if (m_left <= 0) begin
                  m_mode = M_IDLE;
                  m_left = 0;
               end
            end
         end
      endcase
   endtask

   task automatic check_model();
      check("xpos",  32'(xpos_bullet_red),      m_x);
      check("ypos",  32'(ypos_bullet_red),      m_y);
      check("dir",   32'(direction_from_enemy), m_dir);
      check("hit",   32'(tank_enemy_hit_us),    m_hit);
      check("busy",  32'(busy),                 (m_mode != M_IDLE) ? 1 : 0);
      check("count", 32'(hit_count),            m_hits);
   endtask

   // Inputs are set by the caller before this; they return to idle after.
   task automatic cycle();
      @(posedge clk);
      if (!rst) model_clock();
      @(negedge clk);
      check_model();
      frame_tick = 1'b0;
      fire       = 1'b0;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cycle();
      cycle();
   endtask

   task automatic do_fire(input logic [2:0] d, input logic [9:0] x, input logic [9:0] y);
      fire       = 1'b1;
      fire_dir   = d;
      xpos_enemy = x;
      ypos_enemy = y;
      cycle();
   endtask

   // Reset asserted between clock edges; outputs must clear before the next edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_model();
      check("rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      frame_tick = 1'b0;
      fire       = 1'b0;
      fire_dir   = 3'd0;
      xpos_enemy = '0;
      ypos_enemy = '0;
      xpos_us    = 12'd500;
      ypos_us    = 12'd500;
      model_reset();
      repeat (2) @(negedge clk);
      check_model();
      rst = 1'b0;
      cycle();

      // Upward shell, tank far away.
      do_fire(3'd1, 10'd100, 10'd300);
      check("launch_dir", 32'(direction_from_enemy), 1);
      check("launch_busy", 32'(busy), 1);
      repeat (3) tick();
      check("up3_x", 32'(xpos_bullet_red), 100);
      check("up3_y", 32'(ypos_bullet_red), 288);
      check("up3_dir", 32'(direction_from_enemy), 1);

      // Async reset mid-flight; first fire afterwards is accepted at once.
      async_reset();

      // Rightward shell towards our tank: hit when distance reaches 16.
      xpos_us = 12'd140;
      ypos_us = 12'd200;
      do_fire(3'd3, 10'd100, 10'd200);
      check("after_rst_busy", 32'(busy), 1);
      repeat (5) tick();
      check("r5_x", 32'(xpos_bullet_red), 120);
      tick();
      check("r6_x", 32'(xpos_bullet_red), 124);
      check("r6_hit", 32'(tank_enemy_hit_us), 0);
      frame_tick = 1'b1;
      cycle();
      check("r7_hit", 32'(tank_enemy_hit_us), 1);
      check("r7_dir", 32'(direction_from_enemy), 0);
      check("r7_count", 32'(hit_count), 1);
      repeat (3) cycle();
      check("hit_hold", 32'(tank_enemy_hit_us), 1);
      frame_tick = 1'b1;
      cycle();
      check("hit_end", 32'(tank_enemy_hit_us), 0);
      check("hit_end_busy", 32'(busy), 1);
      repeat (29) tick();
      check("cd29_busy", 32'(busy), 1);
      tick();
      check("cd30_busy", 32'(busy), 0);

      // Leftward shell hitting the left edge, fire ignored during cooldown.
      xpos_us = 12'd700;
      ypos_us = 12'd500;
      do_fire(3'd4, 10'd6, 10'd50);
      tick();
      check("l1_x", 32'(xpos_bullet_red), 2);
      tick();
      check("l2_x", 32'(xpos_bullet_red), 2);
      check("l2_dir", 32'(direction_from_enemy), 0);
      check("l2_busy", 32'(busy), 1);
      for (int i = 0; i < 29; i++) begin
         fire = 1'b1; fire_dir = 3'd3; xpos_enemy = 10'd400; frame_tick = 1'b1;
         cycle();
         fire = 1'b1; fire_dir = 3'd2;
         cycle();
      end
      check("cd_fire_ign", 32'(xpos_bullet_red), 2);
      check("cd_busy", 32'(busy), 1);
      tick();
      check("cd_done", 32'(busy), 0);

      // Invalid directions are ignored.
      do_fire(3'd5, 10'd300, 10'd300);
      check("dir5_busy", 32'(busy), 0);
      do_fire(3'd0, 10'd300, 10'd300);
      check("dir0_busy", 32'(busy), 0);
      check("dir0_x", 32'(xpos_bullet_red), 2);

      // Fire with a frame tick in the same cycle: no move; then bottom edge.
      fire = 1'b1; fire_dir = 3'd2; xpos_enemy = 10'd300; ypos_enemy = 10'd100;
      frame_tick = 1'b1;
      cycle();
      check("same_tick_y", 32'(ypos_bullet_red), 100);
      repeat (125) tick();
      check("bottom_y", 32'(ypos_bullet_red), 596);
      check("bottom_dir", 32'(direction_from_enemy), 0);
      repeat (30) tick();

      // Right edge.
      xpos_us = 12'd100;
      do_fire(3'd3, 10'd790, 10'd10);
      repeat (3) tick();
      check("right_x", 32'(xpos_bullet_red), 798);
      check("right_busy", 32'(busy), 1);
      repeat (30) tick();

      // Reset during HIT drops the flag without touching the count further.
      xpos_us = 12'd110; ypos_us = 12'd200;
      do_fire(3'd3, 10'd100, 10'd200);
      tick();
      check("pre_rst_hit", 32'(tank_enemy_hit_us), 1);
      async_reset();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) begin
            fire       = 1'b1;
            fire_dir   = 3'($urandom_range(0, 7));
            xpos_enemy = 10'($urandom_range(0, 799));
            ypos_enemy = 10'($urandom_range(0, 599));
            if (m_mode == M_IDLE) begin
               xpos_us = 12'(int'(xpos_enemy) + int'($urandom_range(0, 160)) - 80);
               ypos_us = 12'(int'(ypos_enemy) + int'($urandom_range(0, 160)) - 80);
            end
         end
         cycle();
      end

      // Saturation of the hit counter.
      async_reset();
      xpos_us = 12'd110; ypos_us = 12'd200;
      for (int n = 0; n < 16; n++) begin
         do_fire(3'd3, 10'd100, 10'd200);
         tick();
         tick();
         repeat (30) tick();
      end
      check("sat_count", 32'(hit_count), 15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
